// File: rtl/soc_store_drain.sv
// ============================================================================
// Module   : soc_store_drain
// Brief    : M-stage store formatter and in-order store buffer draining to the
//            data-memory write port, with pipeline stall and load-hit flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
`ifndef XLEN_128b
`define XLEN_128b 3
`endif

module soc_store_drain #(
  parameter int XLEN  = `XLEN_64b,
  parameter int DEPTH = 4,
  localparam int W  = 1 << (XLEN + 4),
  localparam int S  = W / 8,
  localparam int OB = $clog2(S)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clk_en,
  input  logic         i_sw_m,
  input  logic [W-1:0] i_mem_data_m,
  input  logic [W-1:0] i_mem_addr_m,
  input  logic         i_store_byte_m,
  input  logic         i_store_half_m,
  output logic         o_stall,
  output logic         o_bus_valid,
  output logic [W-1:0] o_bus_addr,
  output logic [W-1:0] o_bus_wdata,
  output logic [S-1:0] o_bus_wstrb,
  input  logic         i_bus_ready,
  output logic         o_empty,
  input  logic [W-1:0] i_ld_addr,
  output logic         o_ld_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [W-1:0]  r_addr  [DEPTH];
  logic [W-1:0]  r_wdata [DEPTH];
  logic [S-1:0]  r_wstrb [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [OB-1:0] w_off;
  logic [OB-1:0] w_lane;
  logic [W-1:0]  w_data_in;
  logic [W-1:0]  w_fmt_wdata;
  logic [S-1:0]  w_fmt_wstrb;
  logic [W-1:0]  w_fmt_addr;
  logic [W-1:0]  w_ld_aligned;
  logic [DEPTH-1:0] w_hit_vec;
  logic          w_unused;

  assign w_full  = (r_count == C_FULL);
  assign w_push  = i_clk_en & i_sw_m & ~w_full;
  assign w_pop   = o_bus_valid & i_bus_ready;

  assign o_stall     = i_sw_m & w_full;
  assign o_bus_valid = (r_count != '0);
  assign o_empty     = (r_count == '0);
  assign o_bus_addr  = r_addr[r_rd_ptr];
  assign o_bus_wdata = r_wdata[r_rd_ptr];
  assign o_bus_wstrb = r_wstrb[r_rd_ptr];

  assign w_fmt_addr   = {i_mem_addr_m[W-1:OB], OB'(0)};
  assign w_ld_aligned = {i_ld_addr[W-1:OB], OB'(0)};
  assign w_unused     = ^{i_mem_data_m, i_ld_addr[OB-1:0]};

  // Byte wins over half; the lane offset is rounded down to the access size.
  always_comb begin
    w_off       = i_mem_addr_m[OB-1:0];
    w_lane      = w_off;
    w_fmt_wstrb = '0;
    w_data_in   = '0;
    if (i_store_byte_m) begin
      w_lane      = w_off;
      w_fmt_wstrb = S'(1) << w_lane;
      w_data_in   = W'(i_mem_data_m[7:0]);
    end else if (i_store_half_m) begin
      w_lane      = w_off & ~OB'(1);
      w_fmt_wstrb = S'(3) << w_lane;
      w_data_in   = W'(i_mem_data_m[15:0]);
    end else begin
      w_lane      = w_off & ~OB'(3);
      w_fmt_wstrb = S'(15) << w_lane;
      w_data_in   = W'(i_mem_data_m[31:0]);
    end
    w_fmt_wdata = w_data_in << {w_lane, 3'b000};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
        r_wstrb[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_wr_ptr]  <= w_fmt_addr;
        r_wdata[r_wr_ptr] <= w_fmt_wdata;
        r_wstrb[r_wr_ptr] <= w_fmt_wstrb;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is occupied when its distance from the head is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    logic [PW-1:0] w_rel;
    assign w_rel         = PW'(gi) - r_rd_ptr;
    assign w_hit_vec[gi] = (CW'(w_rel) < r_count) && (r_addr[gi] == w_ld_aligned);
  end

  assign o_ld_hit = |w_hit_vec;

endmodule

`default_nettype wire

// File: tb/tb_soc_store_drain.sv
// ============================================================================
// Module   : tb_soc_store_drain
// Brief    : Directed self-checking bench for soc_store_drain (W=64, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soc_store_drain;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        sw_m;
  logic [63:0] mem_data;
  logic [63:0] mem_addr;
  logic        st_byte;
  logic        st_half;
  logic        stall;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_ready;
  logic        empty;
  logic [63:0] ld_addr;
  logic        ld_hit;

  int checks   = 0;
  int failures = 0;

  soc_store_drain #(.XLEN(2), .DEPTH(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_clk_en       (clk_en),
    .i_sw_m         (sw_m),
    .i_mem_data_m   (mem_data),
    .i_mem_addr_m   (mem_addr),
    .i_store_byte_m (st_byte),
    .i_store_half_m (st_half),
    .o_stall        (stall),
    .o_bus_valid    (bus_valid),
    .o_bus_addr     (bus_addr),
    .o_bus_wdata    (bus_wdata),
    .o_bus_wstrb    (bus_wstrb),
    .i_bus_ready    (bus_ready),
    .o_empty        (empty),
    .i_ld_addr      (ld_addr),
    .o_ld_hit       (ld_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic v, input logic b, input logic h,
                           input logic [63:0] a, input logic [63:0] d);
    sw_m     = v;
    st_byte  = b;
    st_half  = h;
    mem_addr = a;
    mem_data = d;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [63:0] a,
                          input logic [63:0] d, input logic [7:0] s);
    chk({tag, "_valid"}, 64'(bus_valid), 64'd1);
    chk({tag, "_addr"},  bus_addr,  a);
    chk({tag, "_wdata"}, bus_wdata, d);
    chk({tag, "_wstrb"}, 64'(bus_wstrb), 64'(s));
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; bus_ready = 1'b0; ld_addr = 64'h0;
    set_store(1'b1, 1'b0, 1'b0, 64'h40, 64'h55);

    // Reset held for two edges with a store request pending
    tick(); tick();
    chk("rst_valid", 64'(bus_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ldhit", 64'(ld_hit), 64'd0);
    chk("rst_addr",  bus_addr, 64'h0);
    chk("rst_wdata", bus_wdata, 64'h0);
    chk("rst_wstrb", 64'(bus_wstrb), 64'h0);
    set_store(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_no_accept", 64'(empty), 64'd1);

    // Byte store and load hazard
    set_store(1'b1, 1'b1, 1'b0, 64'h1003, 64'hFFFF_FFAB);
    tick();
    set_store(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    chk_head("byte", 64'h1000, 64'h0000_0000_AB00_0000, 8'h08);
    chk("byte_empty", 64'(empty), 64'd0);
    ld_addr = 64'h1006; #1;
    chk("ldhit_same_word", 64'(ld_hit), 64'd1);
    ld_addr = 64'h1008; #1;
    chk("ldhit_next_word", 64'(ld_hit), 64'd0);
    ld_addr = 64'h1006; bus_ready = 1'b1; #1;
    chk("ldhit_while_pop", 64'(ld_hit), 64'd1);
    tick();
    bus_ready = 1'b0; #1;
    chk("ldhit_after_pop", 64'(ld_hit), 64'd0);
    chk("byte_drained", 64'(empty), 64'd1);

    // Half store
    set_store(1'b1, 1'b0, 1'b1, 64'h2006, 64'hAAAA_1234);
    tick();
    set_store(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    chk_head("half", 64'h2000, 64'h1234_0000_0000_0000, 8'hC0);
    bus_ready = 1'b1; tick(); bus_ready = 1'b0;

    // Word store
    set_store(1'b1, 1'b0, 1'b0, 64'h3004, 64'h1111_2222_DEAD_BEEF);
    tick();
    set_store(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    chk_head("word", 64'h3000, 64'hDEAD_BEEF_0000_0000, 8'hF0);
    bus_ready = 1'b1; tick(); bus_ready = 1'b0; #1;
    chk("word_drained", 64'(empty), 64'd1);

    // Fill with A..D under backpressure
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 1'b0, 1'b0, 64'h100 + 64'(8 * i), 64'hA + 64'(i));
      chk($sformatf("fill_nostall_%0d", i), 64'(stall), 64'd0);
      tick();
    end
    set_store(1'b1, 1'b0, 1'b0, 64'h200, 64'hE);
    chk("full_stall", 64'(stall), 64'd1);
    bus_ready = 1'b1; #1;
    chk("full_stall_ready", 64'(stall), 64'd1);
    bus_ready = 1'b0; #1;
    tick();
    set_store(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    chk("full_nosw_stall", 64'(stall), 64'd0);
    bus_ready = 1'b1; #1;
    chk_head("pop_A", 64'h100, 64'hA, 8'h0F); tick();
    chk_head("pop_B", 64'h108, 64'hB, 8'h0F); tick();
    chk_head("pop_C", 64'h110, 64'hC, 8'h0F); tick();
    chk_head("pop_D", 64'h118, 64'hD, 8'h0F); tick();
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_valid", 64'(bus_valid), 64'd0);
    bus_ready = 1'b0;

    // Same-cycle push and pop at count 2
    set_store(1'b1, 1'b0, 1'b0, 64'h400, 64'h1); tick();
    set_store(1'b1, 1'b0, 1'b0, 64'h408, 64'h2); tick();
    set_store(1'b1, 1'b0, 1'b0, 64'h410, 64'h3); bus_ready = 1'b1; tick();
    set_store(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    chk_head("pp_head2", 64'h408, 64'h2, 8'h0F); tick();
    chk_head("pp_head3", 64'h410, 64'h3, 8'h0F); tick();
    chk("pp_empty", 64'(empty), 64'd1);
    bus_ready = 1'b0;

    // Clock enable low blocks push but not drain
    set_store(1'b1, 1'b0, 1'b0, 64'h500, 64'h77); tick();
    clk_en = 1'b0;
    set_store(1'b1, 1'b0, 1'b0, 64'h508, 64'h88);
    bus_ready = 1'b1; #1;
    chk_head("ce_head", 64'h500, 64'h77, 8'h0F);
    tick();
    chk("ce_drained", 64'(empty), 64'd1);
    tick();
    chk("ce_no_push", 64'(bus_valid), 64'd0);
    clk_en = 1'b1; bus_ready = 1'b0;
    set_store(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

    // Reset mid-drain discards pending entries
    set_store(1'b1, 1'b0, 1'b0, 64'h600, 64'h9); tick();
    set_store(1'b1, 1'b0, 1'b0, 64'h608, 64'hA); tick();
    set_store(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    bus_ready = 1'b1; rst_n = 1'b0; #1;
    tick();
    rst_n = 1'b1; #1;
    chk("midrst_valid", 64'(bus_valid), 64'd0);
    chk("midrst_empty", 64'(empty), 64'd1);
    chk("midrst_addr", bus_addr, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
